fast_field_op_sequencer: RTL and testbench

Two-slot (ping-pong) buffer and issue scheduler between the FAST op generator and the per-field decode/dictionary engine. Accepts one message's worth of field ops (up to MAX_FIELDS words) in a single handshake. Issues the ops one per cycle in field order over a valid/ready interface. Loading of message N+1 overlaps draining of message N.

---
 rtl/fast_field_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fast_field_op_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_field_op_sequencer.sv
// FAST field-op sequencer: two-slot ping-pong op buffer that issues one field op per cycle.
// Ports: clk/rstn (sync, active-low), flush; msg_* load handshake; op_* issue handshake;
// msg_done pulse; sticky err_count_* flags; stat_* counters (built only with FAST_SEQ_STATS_EN).
module fast_field_op_sequencer #(
  parameter int FIELD_OP_W = 32,
  parameter int MAX_FIELDS = 10,
  parameter int CNT_W = $clog2(MAX_FIELDS + 1),
  parameter int IDX_W = $clog2(MAX_FIELDS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [CNT_W-1:0]      msg_field_count,
  input  logic [FIELD_OP_W-1:0] msg_ops [MAX_FIELDS],
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [FIELD_OP_W-1:0] op_data,
  output logic [IDX_W-1:0]      op_index,
  output logic                  op_last,
  output logic                  msg_done,
  output logic                  err_count_zero,
  output logic                  err_count_clamp,
  output logic [31:0]           stat_msgs,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_stall
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, state_n;

  logic [1:0]            full, full_n;
  logic [CNT_W-1:0]      cnt [2];
  logic [FIELD_OP_W-1:0] ops [2][MAX_FIELDS];
  logic                  wr_ptr, rd_ptr, rd_ptr_n;
  logic [IDX_W-1:0]      idx, idx_n;

  logic                  hs, last_hs, load, alloc, fwd;
  logic [CNT_W-1:0]      cnt_in, cnt_sel;
  logic [FIELD_OP_W-1:0] data_sel;

  assign hs      = op_valid & op_ready & ~flush;
  assign last_hs = hs & op_last;
  assign load    = msg_valid & msg_ready & ~flush;
  assign alloc   = load & (msg_field_count != '0);
  assign cnt_in  = (msg_field_count > CNT_W'(MAX_FIELDS))
                 ? CNT_W'(MAX_FIELDS) : msg_field_count;

  always_comb begin
    full_n = full;
    if (last_hs) full_n[rd_ptr] = 1'b0;
    if (alloc)   full_n[wr_ptr] = 1'b1;
  end

  assign rd_ptr_n = rd_ptr ^ last_hs;

  always_comb begin
    idx_n = idx;
    if (last_hs)  idx_n = '0;
    else if (hs)  idx_n = idx + IDX_W'(1);
  end

  // A load landing in the slot about to be read is forwarded straight
  // into the issue registers, so op_valid rises one cycle after accept.
  assign fwd      = alloc & (wr_ptr == rd_ptr_n);
  assign cnt_sel  = fwd ? cnt_in : cnt[rd_ptr_n];
  assign data_sel = fwd ? msg_ops[idx_n] : ops[rd_ptr_n][idx_n];

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (full_n[rd_ptr_n])  state_n = ISSUE;
      ISSUE: if (!full_n[rd_ptr_n]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_comb begin
    op_valid = (state == ISSUE);
    msg_done = last_hs;
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      full      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      idx       <= '0;
      msg_ready <= 1'b1;
      op_data   <= '0;
      op_index  <= '0;
      op_last   <= 1'b0;
    end else begin
      full      <= full_n;
      wr_ptr    <= wr_ptr ^ alloc;
      rd_ptr    <= rd_ptr_n;
      idx       <= idx_n;
      msg_ready <= ~&full_n;
      if (state_n == ISSUE) begin
        op_data  <= data_sel;
        op_index <= idx_n;
        op_last  <= (CNT_W'(idx_n) == cnt_sel - CNT_W'(1));
      end else begin
        op_data  <= '0;
        op_index <= '0;
        op_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      cnt[wr_ptr] <= cnt_in;
      for (int i = 0; i < MAX_FIELDS; i++)
        ops[wr_ptr][i] <= msg_ops[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_count_zero  <= 1'b0;
      err_count_clamp <= 1'b0;
    end else if (load) begin
      if (msg_field_count == '0)
        err_count_zero <= 1'b1;
      if (msg_field_count > CNT_W'(MAX_FIELDS))
        err_count_clamp <= 1'b1;
    end
  end

`ifdef FAST_SEQ_STATS_EN
  logic stall;
  assign stall = op_valid & ~op_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_msgs  <= '0;
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (msg_done && stat_msgs != '1)
        stat_msgs <= stat_msgs + 32'd1;
      if (hs && stat_ops != '1)
        stat_ops <= stat_ops + 32'd1;
      if (stall && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_msgs  = '0;
  assign stat_ops   = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fast_field_op_sequencer.sv
// Self-checking bench for fast_field_op_sequencer.
// Scoreboard of expected ops plus a table of message scenarios and hand sequences.
module tb_fast_field_op_sequencer;

  localparam int W  = 32;
  localparam int N  = 10;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
`ifdef FAST_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, flush, msg_valid, msg_ready;
  logic [CW-1:0] msg_field_count;
  logic [W-1:0]  msg_ops [N];
  logic          op_valid, op_ready, op_last, msg_done;
  logic [W-1:0]  op_data;
  logic [IW-1:0] op_index;
  logic          err_count_zero, err_count_clamp;
  logic [31:0]   stat_msgs, stat_ops, stat_stall;

  fast_field_op_sequencer dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_field_count(msg_field_count), .msg_ops(msg_ops),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .op_index(op_index), .op_last(op_last), .msg_done(msg_done),
    .err_count_zero(err_count_zero), .err_count_clamp(err_count_clamp),
    .stat_msgs(stat_msgs), .stat_ops(stat_ops), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    int          cnt;
    int          stall;
    logic [15:0] base;
    bit          ezero;
    bit          eclamp;
    int          eops;
  } vec_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int n_ops = 0, n_msgs = 0, n_stall = 0;
  logic exp_done;
  logic prev_stall = 1'b0, prev_flush = 1'b0, pl;
  logic [W-1:0] pd;
  logic [IW-1:0] pi;

  function automatic logic [W-1:0] mk(input logic [15:0] base, input int i);
    return {base, 16'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", 64'(op_valid), 64'd1);
        chk("hold_data", 64'(op_data), 64'(pd));
        chk("hold_index", 64'(op_index), 64'(pi));
        chk("hold_last", 64'(op_last), 64'(pl));
      end
      if (op_valid && op_ready && !flush) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op: got %0h expected none", op_data);
        end else begin
          e = q.pop_front();
          chk("op_data", 64'(op_data), 64'(e.data));
          chk("op_index", 64'(op_index), 64'(e.idx));
          chk("op_last", 64'(op_last), 64'(e.last));
          exp_done = e.last;
          n_ops++;
          if (e.last) n_msgs++;
        end
      end
      if (op_valid && !op_ready) n_stall++;
      chk("msg_done", 64'(msg_done), 64'(exp_done));
      prev_stall = op_valid && !op_ready;
      prev_flush = flush;
      pd = op_data;
      pi = op_index;
      pl = op_last;
    end
  end

  task automatic send(input int cnt, input logic [15:0] base,
                      output int waited);
    int n;
    msg_field_count = CW'(cnt);
    for (int i = 0; i < N; i++) msg_ops[i] = mk(base, i);
    msg_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!msg_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (!msg_ready) begin
      errors++;
      $display("FAIL load_timeout: got msg_ready 0 expected 1");
    end else begin
      n = (cnt > N) ? N : cnt;
      for (int i = 0; i < n; i++)
        q.push_back('{mk(base, i), IW'(i), (i == n - 1)});
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !op_valid) break;
      tick();
    end
    chk("drain", 64'(q.size() == 0 && !op_valid), 64'd1);
  endtask

  task automatic chk_stats();
    chk("stat_ops", 64'(stat_ops), STATS ? 64'(n_ops) : 64'd0);
    chk("stat_msgs", 64'(stat_msgs), STATS ? 64'(n_msgs) : 64'd0);
    chk("stat_stall", 64'(stat_stall), STATS ? 64'(n_stall) : 64'd0);
  endtask

  vec_t tbl[6];
  int w1, w2, w3, ops0, msgs0, stall0;

  initial begin
    tbl[0] = '{3,  0, 16'h00A0, 1'b0, 1'b0, 3};
    tbl[1] = '{3,  5, 16'h00B0, 1'b0, 1'b0, 3};
    tbl[2] = '{0,  0, 16'h00C0, 1'b1, 1'b0, 0};
    tbl[3] = '{12, 0, 16'h00D0, 1'b1, 1'b1, 10};
    tbl[4] = '{1,  0, 16'h00E0, 1'b1, 1'b1, 1};
    tbl[5] = '{10, 3, 16'h00F0, 1'b1, 1'b1, 10};

    rstn = 1'b0;
    flush = 1'b0;
    op_ready = 1'b1;
    msg_valid = 1'b1;
    msg_field_count = CW'(3);
    for (int i = 0; i < N; i++) msg_ops[i] = mk(16'h0099, i);
    tick();
    tick();
    chk("rst_msg_ready", 64'(msg_ready), 64'd1);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_op_data", 64'(op_data), 64'd0);
    chk("rst_op_index", 64'(op_index), 64'd0);
    chk("rst_op_last", 64'(op_last), 64'd0);
    chk("rst_err_zero", 64'(err_count_zero), 64'd0);
    chk("rst_err_clamp", 64'(err_count_clamp), 64'd0);
    chk_stats();
    msg_valid = 1'b0;
    rstn = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_no_load", 64'(op_valid), 64'd0);

    for (int t = 0; t < 6; t++) begin
      ops0 = n_ops;
      msgs0 = n_msgs;
      stall0 = n_stall;
      op_ready = (tbl[t].stall == 0);
      send(tbl[t].cnt, tbl[t].base, w1);
      if (tbl[t].stall != 0) begin
        repeat (tbl[t].stall) tick();
        op_ready = 1'b1;
      end
      wait_drain();
      chk("vec_ops", 64'(n_ops - ops0), 64'(tbl[t].eops));
      chk("vec_msgs", 64'(n_msgs - msgs0), 64'(tbl[t].eops > 0));
      chk("vec_stall", 64'(n_stall - stall0), 64'(tbl[t].stall));
      chk("vec_err_zero", 64'(err_count_zero), 64'(tbl[t].ezero));
      chk("vec_err_clamp", 64'(err_count_clamp), 64'(tbl[t].eclamp));
      chk_stats();
    end

    op_ready = 1'b1;
    fork
      begin
        send(2, 16'h0100, w1);
        send(4, 16'h0200, w2);
        chk("b2b_ready_low", 64'(msg_ready), 64'd0);
        chk("b2b_first_done", 64'(msg_done), 64'd1);
        send(1, 16'h0300, w3);
        chk("b2b_wait_second", 64'(w2), 64'd0);
        chk("b2b_wait_third", 64'(w3), 64'd1);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          chk("b2b_no_bubble", 64'(op_valid), 64'd1);
        end
      end
    join
    wait_drain();
    chk_stats();

    ops0 = n_ops;
    send(5, 16'h0400, w1);
    tick();
    tick();
    flush = 1'b1;
    op_ready = 1'b0;
    msg_valid = 1'b1;
    msg_field_count = CW'(2);
    for (int i = 0; i < N; i++) msg_ops[i] = mk(16'h0500, i);
    #1;
    chk("flush_no_done", 64'(msg_done), 64'd0);
    tick();
    flush = 1'b0;
    msg_valid = 1'b0;
    q.delete();
    chk("flush_op_valid", 64'(op_valid), 64'd0);
    chk("flush_msg_ready", 64'(msg_ready), 64'd1);
    tick();
    chk("flush_drop_load", 64'(op_valid), 64'd0);
    chk("flush_ops_kept", 64'(n_ops - ops0), 64'd2);
    chk_stats();
    op_ready = 1'b1;
    send(2, 16'h0600, w1);
    wait_drain();
    chk("flush_err_kept", 64'(err_count_clamp), 64'd1);
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
